// File: rtl/uart_tx_serializer_p.sv
// Parallel-to-serial shifter for the UART TX datapath, LSB- or MSB-first, one bit per ser_en.
// Define UART_SER_SKID_EN to add a one-word holding buffer for gapless back-to-back words.
module uart_tx_serializer_p #(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b0,
  parameter bit IDLE_LEVEL = 1'b1,
  localparam int CW = $clog2(DATA_WIDTH)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  output logic                  Data_Ready,
  input  logic                  ser_en,
  output logic                  ser_data,
  output logic                  ser_done,
  output logic                  busy,
  output logic [CW-1:0]         bit_cnt
);

  typedef enum logic {S_IDLE, S_SHIFT} state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] sh_q;
  logic [CW-1:0]         cnt_q;
  logic                  sd_q, done_q;
  logic                  accept, last, fin, load_d;
  logic [DATA_WIDTH-1:0] word_d;

  // The bit leaving the shifter always sits at the output end; the rest moves toward it.
  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
    return MSB_FIRST ? w[DATA_WIDTH-1] : w[0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  assign accept = Data_Valid & Data_Ready;
  assign last   = (cnt_q == CW'(DATA_WIDTH - 1));
  assign fin    = (state_q == S_SHIFT) & ser_en & last;

`ifdef UART_SER_SKID_EN
  logic [DATA_WIDTH-1:0] buf_q;
  logic                  full_q;

  assign Data_Ready = ~full_q;

  // A finishing word hands over to the buffered word, or to a word accepted on that same edge.
  always_comb begin
    load_d = 1'b0;
    word_d = P_DATA;
    if (state_q == S_IDLE) begin
      load_d = accept;
    end else if (fin) begin
      load_d = full_q | accept;
      word_d = full_q ? buf_q : P_DATA;
    end
  end
`else
  assign Data_Ready = (state_q == S_IDLE) & ~RST;

  always_comb begin
    load_d = accept;
    word_d = P_DATA;
  end
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      sd_q    <= IDLE_LEVEL;
      done_q  <= 1'b0;
`ifdef UART_SER_SKID_EN
      buf_q   <= '0;
      full_q  <= 1'b0;
`endif
    end else begin
      done_q <= fin;
      if (load_d) begin
        state_q <= S_SHIFT;
        cnt_q   <= '0;
        sd_q    <= first_bit(word_d);
        sh_q    <= shift_out(word_d);
      end else if (state_q == S_SHIFT && ser_en) begin
        if (last) begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          sd_q    <= IDLE_LEVEL;
          sh_q    <= '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
          sd_q  <= first_bit(sh_q);
          sh_q  <= shift_out(sh_q);
        end
      end
`ifdef UART_SER_SKID_EN
      if (fin && full_q)
        full_q <= 1'b0;
      if (accept && state_q == S_SHIFT && !fin) begin
        buf_q  <= P_DATA;
        full_q <= 1'b1;
      end
`endif
    end
  end

  assign ser_data = sd_q;
  assign ser_done = done_q;
  assign busy     = (state_q == S_SHIFT);
  assign bit_cnt  = cnt_q;

endmodule

// File: tb/tb_uart_tx_serializer_p.sv
// Bench for uart_tx_serializer_p: an LSB-first/idle-high and an MSB-first/idle-low instance
// share stimulus; a word-queue reference model feeds an expected-output scoreboard.
module tb_uart_tx_serializer_p;
  localparam int DW = 8;
  localparam int CW = 3;
`ifdef UART_SER_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [DW-1:0] P_DATA = '0;
  logic          Data_Valid = 1'b0;
  logic          ser_en = 1'b0;

  logic          rdy_a, sd_a, done_a, busy_a;
  logic          rdy_b, sd_b, done_b, busy_b;
  logic [CW-1:0] cnt_a, cnt_b;

  uart_tx_serializer_p #(.DATA_WIDTH(DW), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_a (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid), .Data_Ready(rdy_a),
    .ser_en(ser_en), .ser_data(sd_a), .ser_done(done_a), .busy(busy_a), .bit_cnt(cnt_a));

  uart_tx_serializer_p #(.DATA_WIDTH(DW), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_b (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid), .Data_Ready(rdy_b),
    .ser_en(ser_en), .ser_data(sd_b), .ser_done(done_b), .busy(busy_b), .bit_cnt(cnt_b));

  always #5 CLK = ~CLK;

  typedef struct {
    logic          rdy, sda, sdb, done, busy;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] words[$];   // words[0] is on the wire, words[1] is waiting
  logic [DW-1:0] src_q[$];
  int            idx;
  bit            m_done;
  int            vecs = 0, errs = 0;

  bit            src_pend = 0;
  logic [DW-1:0] src_data = '0;
  bit            p_rst = 1, p_val = 0, p_en = 0;
  logic [DW-1:0] p_dat = '0;

  function automatic bit m_ready(input bit rst);
    if (SKID) return words.size() < 2;
    return (words.size() == 0) && !rst;
  endfunction

  // Advance the model across one clock edge; returns whether a word was taken.
  function automatic bit m_step(input bit rst, input bit val, input logic [DW-1:0] d, input bit en);
    bit acc;
    acc = val && m_ready(rst);
    if (rst) begin
      words.delete();
      idx = 0;
      m_done = 0;
      return 0;
    end
    m_done = 0;
    if (words.size() > 0 && en) begin
      if (idx == DW - 1) begin
        void'(words.pop_front());
        idx = 0;
        m_done = 1;
      end else idx++;
    end
    if (acc) words.push_back(d);
    return acc;
  endfunction

  task automatic tick(input bit r, input bit en);
    exp_t          e;
    logic [DW-1:0] w;
    @(posedge CLK);
    #1;
    if (m_step(p_rst, p_val, p_dat, p_en)) src_pend = 0;
    if (!src_pend && src_q.size() > 0) begin
      src_data = src_q.pop_front();
      src_pend = 1;
    end
    RST = r;
    ser_en = en;
    Data_Valid = src_pend;
    P_DATA = src_pend ? src_data : DW'($urandom);
    p_rst = r; p_en = en; p_val = src_pend; p_dat = P_DATA;
    e.rdy  = m_ready(r);
    e.busy = words.size() > 0;
    e.done = m_done;
    e.cnt  = e.busy ? CW'(idx) : '0;
    if (e.busy) begin
      w = words[0];
      e.sda = w[idx];
      e.sdb = w[DW-1-idx];
    end else begin
      e.sda = 1'b1;
      e.sdb = 1'b0;
    end
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    vecs++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, want);
    end
  endtask

  always @(negedge CLK) begin
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("ready_a", 8'(rdy_a), 8'(e.rdy));
      chk("ready_b", 8'(rdy_b), 8'(e.rdy));
      chk("ser_data_lsb", 8'(sd_a), 8'(e.sda));
      chk("ser_data_msb", 8'(sd_b), 8'(e.sdb));
      chk("ser_done_a", 8'(done_a), 8'(e.done));
      chk("ser_done_b", 8'(done_b), 8'(e.done));
      chk("busy_a", 8'(busy_a), 8'(e.busy));
      chk("busy_b", 8'(busy_b), 8'(e.busy));
      chk("bit_cnt_a", 8'(cnt_a), 8'(e.cnt));
      chk("bit_cnt_b", 8'(cnt_b), 8'(e.cnt));
    end
  end

  initial begin
    idx = 0;
    m_done = 0;
    repeat (3) tick(1, 1);
    // straight run of 8'hBB
    src_q.push_back(8'hBB);
    repeat (12) tick(0, 1);
    // stalled run of 8'hA5
    src_q.push_back(8'hA5);
    for (int i = 0; i < 36; i++) tick(0, (i % 4 == 0) || (i % 4 == 3));
    // reset partway through a word, then a clean word
    src_q.push_back(8'h5A);
    repeat (6) tick(0, 1);
    tick(1, 1);
    src_q.push_back(8'hC3);
    repeat (12) tick(0, 1);
    // back-to-back offers
    src_q.push_back(8'h0F);
    src_q.push_back(8'hF0);
    repeat (22) tick(0, 1);
    // source holding valid while the block is shifting
    src_q.push_back(8'h3C);
    src_q.push_back(8'h3C);
    repeat (24) tick(0, 1);
    // random traffic with stalls and occasional reset
    for (int i = 0; i < 1500; i++) begin
      if (src_q.size() == 0 && $urandom_range(0, 2) != 0) src_q.push_back(DW'($urandom));
      tick($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0);
    end
    repeat (12) tick(0, 1);
    @(negedge CLK);
    #1;
    if (exp_q.size() != 0) begin
      errs++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
